// File: rtl/wb_stage.sv
// wb_stage: writeback stage in front of the register file write port.
// Merges load responses (cannot stall) and execute results (valid/ready).
// Execute results are buffered in a small FIFO while loads hold the port.
// Load data is sign/zero-extended here, and register writes are counted.
module wb_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int RF_SIZE    = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic                  ex_we_i,
  input  logic [RF_SIZE-1:0]    ex_rd_i,
  input  logic [DATA_WIDTH-1:0] ex_data_i,

  input  logic                  lsu_valid_i,
  input  logic [RF_SIZE-1:0]    lsu_rd_i,
  input  logic [2:0]            lsu_funct3_i,
  input  logic [2:0]            lsu_offset_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,

  output logic [RF_SIZE-1:0]    rd_o,
  output logic                  write_enable_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  lsu_err_o,
  output logic [63:0]           wb_count_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // FIFO storage and bookkeeping
  logic [RF_SIZE-1:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Registered write port and status
  logic [RF_SIZE-1:0]    rd_q, rd_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [63:0]           wb_count_q;

  // Per-cycle decisions
  logic                  ex_fire;
  logic                  ex_useful;
  logic                  lsu_claim;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] load_ext;

  logic [7:0]            lsu_byte;
  logic [15:0]           lsu_half;
  logic [31:0]           lsu_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign ex_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
  assign ex_fire    = ex_valid_i & ex_ready_o;
  // Results to x0 or without a register write never need the port
  assign ex_useful  = ex_fire & ex_we_i & (ex_rd_i != '0);
  assign lsu_claim  = lsu_valid_i & (lsu_rd_i != '0) & (lsu_funct3_i != 3'b111);

  // Loads own the port first; otherwise the oldest buffered result drains
  // before any newer execute result, so execute results retire in order.
  assign pop  = ~lsu_claim & ~fifo_empty;
  assign push = ex_useful & (lsu_claim | ~fifo_empty);

  // Select the addressed byte/half/word from the doubleword and extend it
  always_comb begin
    lsu_byte = lsu_data_i[{lsu_offset_i, 3'b000} +: 8];
    lsu_half = lsu_data_i[{lsu_offset_i[2:1], 4'b0000} +: 16];
    lsu_word = lsu_data_i[{lsu_offset_i[2], 5'b00000} +: 32];
    load_ext = '0;
    case (lsu_funct3_i)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lsu_byte[7]}}, lsu_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lsu_half[15]}}, lsu_half};
      3'b010:  load_ext = {{(DATA_WIDTH-32){lsu_word[31]}}, lsu_word};
      3'b011:  load_ext = lsu_data_i;
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lsu_byte};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lsu_half};
      3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}}, lsu_word};
      default: load_ext = '0;
    endcase
  end

  // Choose this cycle's register write and the next FIFO bookkeeping
  always_comb begin
    we_d     = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    err_d    = lsu_valid_i & (lsu_funct3_i == 3'b111);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (lsu_claim) begin
      we_d   = 1'b1;
      rd_d   = lsu_rd_i;
      data_d = load_ext;
    end else if (!fifo_empty) begin
      we_d   = 1'b1;
      rd_d   = fifo_rd_q[rd_ptr_q];
      data_d = fifo_data_q[rd_ptr_q];
    end else if (ex_useful) begin
      we_d   = 1'b1;
      rd_d   = ex_rd_i;
      data_d = ex_data_i;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Buffer entries need no reset; the count decides what is valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= ex_rd_i;
      fifo_data_q[wr_ptr_q] <= ex_data_i;
    end
  end

  // Register pointers, the write port, the error pulse and the write counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
      wb_count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      data_q   <= data_d;
      err_q    <= err_d;
      if (we_d) begin
        wb_count_q <= wb_count_q + 64'd1;
      end
    end
  end

  assign rd_o           = rd_q;
  assign write_enable_o = we_q;
  assign data_o         = data_q;
  assign lsu_err_o      = err_q;
  assign wb_count_o     = wb_count_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table vectors, directed multi-cycle sequences and random
// stimulus for wb_stage, compared against a queue-based reference model.
module tb_wb_stage;

  localparam int DEPTH = 2;

  typedef struct {
    logic        exValid;
    logic        exWe;
    logic [4:0]  exRd;
    logic [63:0] exData;
    logic        lsuValid;
    logic [4:0]  lsuRd;
    logic [2:0]  funct3;
    logic [2:0]  offset;
    logic [63:0] lsuData;
  } stim_t;

  typedef struct {
    string       name;
    stim_t       s;
    logic        expWe;
    logic [4:0]  expRd;
    logic [63:0] expData;
    logic        expErr;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_ready_o, ex_we_i;
  logic [4:0]  ex_rd_i;
  logic [63:0] ex_data_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [2:0]  lsu_funct3_i, lsu_offset_i;
  logic [63:0] lsu_data_i;
  logic [4:0]  rd_o;
  logic        write_enable_o;
  logic [63:0] data_o;
  logic        lsu_err_o;
  logic [63:0] wb_count_o;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state: buffered results plus expected registered outputs
  entry_t      modelQ[$];
  logic        mWe, mErr, mFired;
  logic [4:0]  mRd;
  logic [63:0] mData, mCnt;

  vec_t        vecs[$];
  logic [63:0] tableCount;
  logic [63:0] baseCnt;

  wb_stage #(.DATA_WIDTH(64), .RF_SIZE(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_we_i(ex_we_i),
    .ex_rd_i(ex_rd_i), .ex_data_i(ex_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_funct3_i(lsu_funct3_i),
    .lsu_offset_i(lsu_offset_i), .lsu_data_i(lsu_data_i),
    .rd_o(rd_o), .write_enable_o(write_enable_o), .data_o(data_o),
    .lsu_err_o(lsu_err_o), .wb_count_o(wb_count_o)
  );

  always #5 clk = ~clk;

  // Load extension from the access size: shift, mask, then optionally sign-fill
  function automatic logic [63:0] modelExtend(input logic [2:0] f3, input logic [2:0] off,
                                              input logic [63:0] d);
    int bytes;
    int pos;
    logic [63:0] v;
    logic [63:0] mask;
    bytes = 1 << f3[1:0];
    if (bytes == 8) return d;
    pos  = (int'(off) / bytes) * bytes;
    v    = d >> (pos * 8);
    mask = (64'd1 << (bytes * 8)) - 64'd1;
    v    = v & mask;
    if (!f3[2] && v[bytes*8-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic stim_t mkStim(input logic exV, input logic exW, input logic [4:0] exR,
                                   input logic [63:0] exD, input logic lV, input logic [4:0] lR,
                                   input logic [2:0] f3, input logic [2:0] off,
                                   input logic [63:0] lD);
    stim_t s;
    s.exValid = exV; s.exWe = exW; s.exRd = exR; s.exData = exD;
    s.lsuValid = lV; s.lsuRd = lR; s.funct3 = f3; s.offset = off; s.lsuData = lD;
    return s;
  endfunction

  function automatic stim_t idleStim();
    return mkStim(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0);
  endfunction

  task automatic addVec(input string name, input stim_t s, input logic we,
                        input logic [4:0] rd, input logic [63:0] data, input logic err);
    vec_t v;
    v.name = name; v.s = s; v.expWe = we; v.expRd = rd; v.expData = data; v.expErr = err;
    vecs.push_back(v);
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    mWe = 1'b0; mErr = 1'b0; mRd = '0; mData = '0; mCnt = '0; mFired = 1'b0;
  endtask

  // One cycle of the writeback rules applied to the model
  task automatic modelStep(input stim_t s);
    bit ready, useful, claim;
    entry_t e;
    ready  = (modelQ.size() < DEPTH);
    mFired = s.exValid && ready;
    useful = mFired && s.exWe && (s.exRd != 0);
    claim  = s.lsuValid && (s.lsuRd != 0) && (s.funct3 != 3'd7);
    mErr   = s.lsuValid && (s.funct3 == 3'd7);
    e.rd   = s.exRd;
    e.data = s.exData;
    mWe    = 1'b0;
    if (claim) begin
      mWe = 1'b1; mRd = s.lsuRd; mData = modelExtend(s.funct3, s.offset, s.lsuData);
      if (useful) modelQ.push_back(e);
    end else if (modelQ.size() > 0) begin
      entry_t h;
      h = modelQ.pop_front();
      mWe = 1'b1; mRd = h.rd; mData = h.data;
      if (useful) modelQ.push_back(e);
    end else if (useful) begin
      mWe = 1'b1; mRd = s.exRd; mData = s.exData;
    end
    if (mWe) mCnt = mCnt + 64'd1;
  endtask

  task automatic applyStimulus(input stim_t s);
    ex_valid_i   = s.exValid;
    ex_we_i      = s.exWe;
    ex_rd_i      = s.exRd;
    ex_data_i    = s.exData;
    lsu_valid_i  = s.lsuValid;
    lsu_rd_i     = s.lsuRd;
    lsu_funct3_i = s.funct3;
    lsu_offset_i = s.offset;
    lsu_data_i   = s.lsuData;
    modelStep(s);
  endtask

  task automatic checkOutput();
    checkVal("ex_ready", {63'd0, ex_ready_o}, {63'd0, (modelQ.size() < DEPTH)});
    checkVal("write_enable", {63'd0, write_enable_o}, {63'd0, mWe});
    checkVal("rd", {59'd0, rd_o}, {59'd0, mRd});
    checkVal("data", data_o, mData);
    checkVal("lsu_err", {63'd0, lsu_err_o}, {63'd0, mErr});
    checkVal("wb_count", wb_count_o, mCnt);
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    stim_t s;
    int exIdx;
    logic [63:0] d;

    d = 64'h8877_6655_4433_2211;
    addVec("bypass",   mkStim(1, 1, 5'd5, 64'h1234, 0, 0, 0, 0, 0), 1, 5'd5, 64'h1234, 0);
    addVec("lhu_off6", mkStim(0, 0, 0, 0, 1, 5'd10, 3'b101, 3'd6, d), 1, 5'd10, 64'h8877, 0);
    addVec("lw_off4",  mkStim(0, 0, 0, 0, 1, 5'd11, 3'b010, 3'd4, d), 1, 5'd11,
           64'hFFFF_FFFF_8877_6655, 0);
    addVec("lwu_off0", mkStim(0, 0, 0, 0, 1, 5'd12, 3'b110, 3'd0, d), 1, 5'd12,
           64'h4433_2211, 0);
    addVec("ld",       mkStim(0, 0, 0, 0, 1, 5'd13, 3'b011, 3'd0, d), 1, 5'd13, d, 0);
    addVec("lbu_off7", mkStim(0, 0, 0, 0, 1, 5'd14, 3'b100, 3'd7, d), 1, 5'd14, 64'h88, 0);
    addVec("lh_off2",  mkStim(0, 0, 0, 0, 1, 5'd15, 3'b001, 3'd2, d), 1, 5'd15, 64'h4433, 0);
    addVec("lh_off6",  mkStim(0, 0, 0, 0, 1, 5'd16, 3'b001, 3'd6, d), 1, 5'd16,
           64'hFFFF_FFFF_FFFF_8877, 0);
    addVec("lb_off1",  mkStim(0, 0, 0, 0, 1, 5'd17, 3'b000, 3'd1, d), 1, 5'd17, 64'h22, 0);
    addVec("ex_rd0",   mkStim(1, 1, 5'd0, 64'h55, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    addVec("ex_we0",   mkStim(1, 0, 5'd9, 64'h66, 0, 0, 0, 0, 0), 0, 0, 0, 0);
    addVec("lsu_rd0",  mkStim(0, 0, 0, 0, 1, 5'd0, 3'b011, 3'd0, d), 0, 0, 0, 0);
    addVec("lsu_f7",   mkStim(0, 0, 0, 0, 1, 5'd4, 3'b111, 3'd0, d), 0, 0, 0, 1);

    // Reset state
    rst = 1'b1;
    applyStimulus(idleStim());
    modelReset();
    repeat (2) @(negedge clk);
    checkVal("rst_we", {63'd0, write_enable_o}, 64'd0);
    checkVal("rst_rd", {59'd0, rd_o}, 64'd0);
    checkVal("rst_data", data_o, 64'd0);
    checkVal("rst_err", {63'd0, lsu_err_o}, 64'd0);
    checkVal("rst_count", wb_count_o, 64'd0);
    checkVal("rst_ready", {63'd0, ex_ready_o}, 64'd1);
    rst = 1'b0;

    // Table vectors, each applied with the buffer empty and followed by an idle cycle
    tableCount = 64'd0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      tick();
      if (vecs[i].expWe) tableCount = tableCount + 64'd1;
      checkVal({vecs[i].name, "_we"}, {63'd0, write_enable_o}, {63'd0, vecs[i].expWe});
      checkVal({vecs[i].name, "_err"}, {63'd0, lsu_err_o}, {63'd0, vecs[i].expErr});
      checkVal({vecs[i].name, "_count"}, wb_count_o, tableCount);
      if (vecs[i].expWe) begin
        checkVal({vecs[i].name, "_rd"}, {59'd0, rd_o}, {59'd0, vecs[i].expRd});
        checkVal({vecs[i].name, "_data"}, data_o, vecs[i].expData);
      end
      applyStimulus(idleStim());
      tick();
      checkVal({vecs[i].name, "_err_pulse"}, {63'd0, lsu_err_o}, 64'd0);
    end

    // Load takes priority while the simultaneous execute result is buffered
    applyStimulus(mkStim(1, 1, 5'd7, 64'hAA, 1, 5'd3, 3'b000, 3'd2, 64'h0000_0000_0080_0000));
    tick();
    checkVal("prio_load_rd", {59'd0, rd_o}, 64'd3);
    checkVal("prio_load_data", data_o, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(idleStim());
    tick();
    checkVal("prio_ex_rd", {59'd0, rd_o}, 64'd7);
    checkVal("prio_ex_data", data_o, 64'hAA);
    checkVal("prio_ex_we", {63'd0, write_enable_o}, 64'd1);

    // Backpressure: four loads while execute offers x1..x3
    baseCnt = mCnt;
    exIdx = 1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc == 2) checkVal("bp_ready_low", {63'd0, ex_ready_o}, 64'd0);
      s = mkStim(exIdx <= 3, 1, 5'(exIdx), 64'h100 + 64'(exIdx),
                 cyc < 4, 5'(20 + cyc), 3'b011, 3'd0, 64'(cyc) * 64'h1111);
      applyStimulus(s);
      if (mFired) exIdx++;
      tick();
    end
    checkVal("bp_all_accepted", 64'(exIdx), 64'd4);
    checkVal("bp_count", wb_count_o, baseCnt + 64'd7);

    // Asynchronous reset with two results buffered
    applyStimulus(mkStim(1, 1, 5'd1, 64'h11, 1, 5'd20, 3'b011, 3'd0, 64'h77));
    tick();
    applyStimulus(mkStim(1, 1, 5'd2, 64'h22, 1, 5'd21, 3'b011, 3'd0, 64'h78));
    tick();
    checkVal("pre_rst_full", {63'd0, ex_ready_o}, 64'd0);
    #2 rst = 1'b1;
    #1;
    checkVal("async_rst_we", {63'd0, write_enable_o}, 64'd0);
    checkVal("async_rst_rd", {59'd0, rd_o}, 64'd0);
    checkVal("async_rst_data", data_o, 64'd0);
    checkVal("async_rst_count", wb_count_o, 64'd0);
    checkVal("async_rst_ready", {63'd0, ex_ready_o}, 64'd1);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(idleStim());
    repeat (3) begin
      tick();
      applyStimulus(idleStim());
    end
    tick();
    checkVal("no_stale_count", wb_count_o, 64'd0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [2:0] f3;
      logic [2:0] off;
      f3  = 3'($urandom_range(0, 7));
      off = 3'($urandom_range(0, 7));
      off = (off >> f3[1:0]) << f3[1:0];
      s = mkStim($urandom_range(0, 99) < 60, $urandom_range(0, 9) != 0,
                 5'($urandom_range(0, 31)), {$urandom, $urandom},
                 $urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), f3, off,
                 {$urandom, $urandom});
      applyStimulus(s);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
